// File: rtl/nios_base_timer_sched_pkg.sv
// Shared constants and state encoding for the nios_base_timer_sched slice.
package nios_base_timer_sched_pkg;

   localparam logic [3:0] ADDR_STATUS    = 4'd0;
   localparam logic [3:0] ADDR_CONTROL   = 4'd1;
   localparam logic [3:0] ADDR_SCHED     = 4'd2;
   localparam logic [3:0] ADDR_CHAN_BASE = 4'd4;

   localparam int GEN_BIT     = 15;
   localparam int ENABLE_BIT  = 0;
   localparam int ONESHOT_BIT = 1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/nios_base_timer_sched_tickq.sv
// Saturating 2-bit tick accumulator with a sticky overrun flag.
module nios_base_timer_sched_tickq (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       clr_ovr,
   output logic [1:0] pend,
   output logic       ovr
);

   logic do_inc;
   logic do_dec;

   // A tick arriving while full is dropped and flagged; a consume still proceeds.
   assign do_inc = inc && (pend != 2'd3);
   assign do_dec = dec && (pend != 2'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend <= 2'd0;
         ovr  <= 1'b0;
      end else begin
         if (inc && (pend == 2'd3))
            ovr <= 1'b1;
         else if (clr_ovr)
            ovr <= 1'b0;
         case ({do_inc, do_dec})
            2'b10:   pend <= pend + 2'd1;
            2'b01:   pend <= pend - 2'd1;
            default: pend <= pend;
         endcase
      end
   end

endmodule

// File: rtl/nios_base_timer_sched.sv
// Multi-channel software-timer scheduler behind a 16-bit Avalon-MM slave.
// Build option NIOS_BASE_TIMER_SCHED_COUNT_READBACK_EN: PERIOD_i reads return the live count.
module nios_base_timer_sched
   import nios_base_timer_sched_pkg::*;
#(
   parameter int NUM_CHAN = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [3:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [15:0]         writedata,
   output logic [15:0]         readdata,
   input  logic                tick_in,
   output logic [NUM_CHAN-1:0] chan_expire,
   output logic                irq
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_CHAN - 1);

   state_t              state;
   logic [2:0]          idx;
   logic [15:0]         period [NUM_CHAN];
   logic [15:0]         count  [NUM_CHAN];
   logic [NUM_CHAN-1:0] en, oneshot, pending, mask;
   logic                gen;

   logic                wr;
   logic [1:0]          tq_pend;
   logic                tq_ovr, tq_inc, tq_dec, tq_clr;
   logic [NUM_CHAN-1:0] wr_hit, step, expire_vec, pending_nxt, mask_nxt;
   logic                gen_nxt, scan_exp;
   logic [15:0]         scan_count, scan_dec, rd_mux;

   // Bus: a write is accepted in any cycle with chipselect high and write_n low;
   // readdata follows address one cycle later with no wait states.
   assign wr     = chipselect && !write_n;
   assign tq_inc = tick_in && gen;
   assign tq_dec = (tq_pend != 2'd0) && ((state == IDLE) || (idx == LAST_IDX));
   assign tq_clr = wr && (address == ADDR_SCHED);

   nios_base_timer_sched_tickq u_tickq (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (tq_inc),
      .dec     (tq_dec),
      .clr_ovr (tq_clr),
      .pend    (tq_pend),
      .ovr     (tq_ovr)
   );

   // One shared decrementer serves whichever channel idx points at.
   always_comb begin
      scan_count = 16'd0;
      wr_hit     = '0;
      step       = '0;
      expire_vec = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         wr_hit[i] = wr && ((address == 4'(ADDR_CHAN_BASE + 2*i)) ||
                            (address == 4'(ADDR_CHAN_BASE + 2*i + 1)));
         if (idx == 3'(i))
            scan_count = count[i];
      end
      scan_dec = scan_count - 16'd1;
      scan_exp = (scan_count <= 16'd1);
      for (int i = 0; i < NUM_CHAN; i++) begin
         step[i]       = (state == SCAN) && (idx == 3'(i)) && en[i] && !wr_hit[i];
         expire_vec[i] = step[i] && scan_exp;
      end
   end

   // Next-state of the irq sources, so irq lines up with the pending bits.
   always_comb begin
      pending_nxt = pending;
      mask_nxt    = mask;
      gen_nxt     = gen;
      if (wr && (address == ADDR_STATUS))
         pending_nxt = pending & ~writedata[NUM_CHAN-1:0];
      pending_nxt = pending_nxt | expire_vec;
      if (wr && (address == ADDR_CONTROL)) begin
         mask_nxt = writedata[NUM_CHAN-1:0];
         gen_nxt  = writedata[GEN_BIT];
      end
   end

   always_comb begin
      rd_mux = 16'd0;
      case (address)
         ADDR_STATUS:  rd_mux = 16'(pending);
         ADDR_CONTROL: rd_mux = {gen, 15'(mask)};
         ADDR_SCHED:   rd_mux = {14'd0, tq_ovr, state == SCAN};
         default: begin
            for (int i = 0; i < NUM_CHAN; i++) begin
`ifdef NIOS_BASE_TIMER_SCHED_COUNT_READBACK_EN
               if (address == 4'(ADDR_CHAN_BASE + 2*i))     rd_mux = count[i];
`else
               if (address == 4'(ADDR_CHAN_BASE + 2*i))     rd_mux = period[i];
`endif
               if (address == 4'(ADDR_CHAN_BASE + 2*i + 1)) rd_mux = {14'd0, oneshot[i], en[i]};
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= 3'd0;
      end else begin
         case (state)
            IDLE: if (tq_pend != 2'd0) begin
               state <= SCAN;
               idx   <= 3'd0;
            end
            SCAN: if (idx == LAST_IDX) begin
               idx <= 3'd0;
               if (tq_pend == 2'd0) state <= IDLE;
            end else begin
               idx <= idx + 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata    <= 16'd0;
         chan_expire <= '0;
         irq         <= 1'b0;
         pending     <= '0;
         mask        <= '0;
         gen         <= 1'b0;
         en          <= '0;
         oneshot     <= '0;
         for (int i = 0; i < NUM_CHAN; i++) begin
            period[i] <= 16'd0;
            count[i]  <= 16'd0;
         end
      end else begin
         readdata    <= rd_mux;
         chan_expire <= expire_vec;
         pending     <= pending_nxt;
         mask        <= mask_nxt;
         gen         <= gen_nxt;
         irq         <= (|(pending_nxt & mask_nxt)) && gen_nxt;
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (wr && (address == 4'(ADDR_CHAN_BASE + 2*i))) begin
               period[i] <= writedata;
               count[i]  <= writedata;
            end else if (wr && (address == 4'(ADDR_CHAN_BASE + 2*i + 1))) begin
               en[i]      <= writedata[ENABLE_BIT];
               oneshot[i] <= writedata[ONESHOT_BIT];
            end else if (step[i]) begin
               if (scan_exp) begin
                  count[i] <= period[i];
                  if (oneshot[i]) en[i] <= 1'b0;
               end else begin
                  count[i] <= scan_dec;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nios_base_timer_sched.sv
// Scoreboard bench for nios_base_timer_sched: expiry pulses and read data are queued and checked by a monitor.
module tb_nios_base_timer_sched;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    address = 4'd0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [15:0]   writedata = 16'd0;
   logic [15:0]   readdata;
   logic          tick_in = 1'b0;
   logic [N-1:0]  chan_expire;
   logic          irq;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [19:0]   exp_q[$];
   logic [15:0]   rd_q[$];
   string         rd_name_q[$];
   logic          rd_req = 1'b0;
   logic          rd_v = 1'b0;

   nios_base_timer_sched #(.NUM_CHAN(N)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .tick_in     (tick_in),
      .chan_expire (chan_expire),
      .irq         (irq)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_v <= rd_req;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [19:0] got, want;
      logic [15:0] rexp;
      string       rname;
      if (rd_v) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_errors++;
            $display("FAIL read_unexpected: readdata=%h, no read queued", readdata);
         end else begin
            rexp  = rd_q.pop_front();
            rname = rd_name_q.pop_front();
            if (readdata !== rexp) begin
               n_errors++;
               $display("FAIL %s: readdata=%h expected %h", rname, readdata, rexp);
            end
         end
      end
      if (chan_expire !== '0) begin
         got = {cyc[15:0], chan_expire};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL expire_unexpected: cycle=%0d chan_expire=%b, none expected", cyc, chan_expire);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               n_errors++;
               $display("FAIL expire: cycle=%0d mask=%b expected cycle=%0d mask=%b",
                        got[19:4], got[3:0], want[19:4], want[3:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   task automatic expect_pulse(input int at, input logic [3:0] m);
      exp_q.push_back({16'(at), m});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [15:0] want, input string nm);
      @(posedge clk); #1;
      address = a; chipselect = 1'b1; write_n = 1'b1;
      rd_q.push_back(want); rd_name_q.push_back(nm); rd_req = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0; rd_req = 1'b0;
   endtask

   task automatic tick(output int c);
      @(posedge clk); #1;
      tick_in = 1'b1; c = cyc;
      @(posedge clk); #1;
      tick_in = 1'b0;
   endtask

   // Tick in cycle c, then a bus write in cycle c+3 (the cycle channel 1 is scanned).
   task automatic tick_collide(input logic [3:0] a, input logic [15:0] d,
                               input logic [3:0] pm, output int c);
      @(posedge clk); #1;
      tick_in = 1'b1; c = cyc;
      if (pm != 4'd0) expect_pulse(c + 4, pm);
      @(posedge clk); #1;
      tick_in = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_readdata", readdata, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      check("rst_expire", 16'(chan_expire), 16'h0000);
      bus_read(4'd0, 16'h0000, "rst_status");
      bus_read(4'd1, 16'h0000, "rst_control");
      bus_read(4'd2, 16'h0000, "rst_sched");

      // periodic channel 0, period 3
      bus_write(4'd4, 16'd3);
      bus_write(4'd5, 16'h0001);
      bus_write(4'd1, 16'h8001);
      for (int k = 1; k <= 9; k++) begin
         tick(c);
         if (k % 3 == 0) expect_pulse(c + 3, 4'b0001);
         idle(4);
         check($sformatf("periodic_irq_t%0d", k), {15'd0, irq}, (k >= 3) ? 16'h0001 : 16'h0000);
         idle(14);
      end
      bus_read(4'd0, 16'h0001, "periodic_status");
      bus_write(4'd0, 16'h0001);
      check("irq_after_clear", {15'd0, irq}, 16'h0000);
      bus_read(4'd0, 16'h0000, "status_cleared");
      bus_write(4'd5, 16'h0000);

      // oneshot channel 2, period 2, masked
      bus_write(4'd8, 16'd2);
      bus_write(4'd9, 16'h0003);
      bus_write(4'd1, 16'h8000);
      for (int k = 1; k <= 4; k++) begin
         tick(c);
         if (k == 2) expect_pulse(c + 5, 4'b0100);
         idle(18);
      end
      bus_read(4'd9, 16'h0002, "oneshot_config");
      check("oneshot_irq_masked", {15'd0, irq}, 16'h0000);
      bus_read(4'd0, 16'h0004, "oneshot_status");
      bus_write(4'd0, 16'h0004);

      // overrun: five back-to-back ticks, channel 1 period 0 marks each scan
      bus_write(4'd6, 16'd0);
      bus_write(4'd7, 16'h0001);
      @(posedge clk); #1;
      tick_in = 1'b1; c = cyc;
      for (int j = 0; j < 4; j++) expect_pulse(c + 4 + 4*j, 4'b0010);
      repeat (5) @(posedge clk);
      #1 tick_in = 1'b0;
      bus_read(4'd2, 16'h0003, "sched_busy_ovr");
      idle(20);
      bus_read(4'd2, 16'h0002, "sched_ovr_sticky");
      bus_write(4'd2, 16'h0000);
      bus_read(4'd2, 16'h0000, "sched_ovr_cleared");

      // collisions on channel 1 (pending[1] is still set from the overrun scans)
      bus_write(4'd6, 16'd1);
      bus_write(4'd7, 16'h0001);
      tick_collide(4'd6, 16'd5, 4'b0000, c);
      idle(16);
      for (int k = 1; k <= 4; k++) begin
         tick(c);
         idle(18);
      end
      tick_collide(4'd0, 16'h0002, 4'b0010, c);
      idle(10);
      bus_read(4'd0, 16'h0002, "status_set_wins");

      // reset while scanning idx 2
      bus_write(4'd10, 16'd1);
      bus_write(4'd11, 16'h0001);
      bus_write(4'd1, 16'h800A);
      check("irq_before_reset", {15'd0, irq}, 16'h0001);
      address = 4'd0;
      tick(c);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      check("readdata_before_reset", readdata, 16'h0002);
      reset_n = 1'b0;
      #1;
      check("reset_readdata", readdata, 16'h0000);
      check("reset_irq", {15'd0, irq}, 16'h0000);
      check("reset_expire", 16'(chan_expire), 16'h0000);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      bus_read(4'd0, 16'h0000, "post_rst_status");
      bus_read(4'd1, 16'h0000, "post_rst_control");
      bus_read(4'd2, 16'h0000, "post_rst_sched");
      bus_read(4'd11, 16'h0000, "post_rst_config3");
      bus_read(4'd10, 16'h0000, "post_rst_period3");
      bus_write(4'd1, 16'h8000);
      for (int k = 0; k < 2; k++) begin
         tick(c);
         idle(18);
      end

      // GEN=0 holds counts; GEN=1 resumes
      bus_write(4'd4, 16'd3);
      bus_write(4'd5, 16'h0001);
      bus_write(4'd1, 16'h8001);
      tick(c);
      idle(18);
      bus_write(4'd1, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         tick(c);
         bus_read(4'd2, 16'h0000, "gen0_no_scan");
         idle(16);
      end
      bus_write(4'd1, 16'h8001);
      tick(c);
      idle(18);
      tick(c);
      expect_pulse(c + 3, 4'b0001);
      idle(18);
      check("gen_resume_irq", {15'd0, irq}, 16'h0001);
      bus_read(4'd4, 16'd3, "period0_readback");
      bus_read(4'd0, 16'h0001, "gen_resume_status");

      // final report
      idle(5);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL expire_missing: %0d pulses still queued, expected 0", exp_q.size());
      end
      n_checks++;
      if (rd_q.size() != 0) begin
         n_errors++;
         $display("FAIL read_missing: %0d reads still queued, expected 0", rd_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
